// File: rtl/instruction_pkg.sv
// Shared definitions for the instruction encoder: opcodes, formats,
// field widths, the stage-1 field bundle and the opcode classifier.
package instruction_pkg;

  localparam int OP_W   = 7;
  localparam int F3_W   = 3;
  localparam int F7_W   = 7;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 32;
  localparam int INST_W = 32;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_R32    = 7'b0111011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_IMM32  = 7'b0011011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [INST_W-1:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } fmt_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [F3_W-1:0]  f3;
    logic [F7_W-1:0]  f7;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } fields_t;

  function automatic fmt_e op_fmt(
    input logic [OP_W-1:0] op
  );
    fmt_e f;
    case (op)
      OP_R, OP_R32:        f = FMT_R;
      OP_IMM, OP_IMM32,
      OP_LOAD, OP_JALR,
      OP_SYSTEM:           f = FMT_I;
      OP_STORE:            f = FMT_S;
      OP_BRANCH:           f = FMT_B;
      OP_LUI, OP_AUIPC:    f = FMT_U;
      OP_JAL:              f = FMT_J;
      default:             f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instruction_imm_packer.sv
// Combinational packer: format + fields -> 32-bit word, plus overflow
// flag when INSTRUCTION_ENCODER_IMM_CHECK_EN is defined (else tied 0).
// Ports: i_fmt, i_f (field bundle) -> o_word, o_ovf.
module instruction_imm_packer
  import instruction_pkg::*;
(
  input  fmt_e              i_fmt,
  input  fields_t           i_f,
  output logic [INST_W-1:0] o_word,
  output logic              o_ovf
);

  logic [IMM_W-1:0] w_imm;
  assign w_imm = i_f.imm;

  always_comb begin
    o_word = NOP;
    unique case (i_fmt)
      FMT_R: o_word = {i_f.f7, i_f.rs2, i_f.rs1,
                       i_f.f3, i_f.rd, i_f.op};
      FMT_I: o_word = {w_imm[11:0], i_f.rs1,
                       i_f.f3, i_f.rd, i_f.op};
      FMT_S: o_word = {w_imm[11:5], i_f.rs2, i_f.rs1,
                       i_f.f3, w_imm[4:0], i_f.op};
      FMT_B: o_word = {w_imm[12], w_imm[10:5],
                       i_f.rs2, i_f.rs1, i_f.f3,
                       w_imm[4:1], w_imm[11], i_f.op};
      FMT_U: o_word = {w_imm[31:12], i_f.rd, i_f.op};
      FMT_J: o_word = {w_imm[20], w_imm[10:1],
                       w_imm[11], w_imm[19:12],
                       i_f.rd, i_f.op};
      default: o_word = NOP;
    endcase
  end

`ifdef INSTRUCTION_ENCODER_IMM_CHECK_EN
  // An immediate fits when every bit above the field's sign bit
  // repeats that sign bit.
  logic w_fit12, w_fit13, w_fit21;
  assign w_fit12 = (w_imm[31:11] == {21{w_imm[11]}});
  assign w_fit13 = (w_imm[31:12] == {20{w_imm[12]}});
  assign w_fit21 = (w_imm[31:20] == {12{w_imm[20]}});

  always_comb begin
    o_ovf = 1'b0;
    unique case (i_fmt)
      FMT_I, FMT_S: o_ovf = !w_fit12;
      FMT_B:        o_ovf = !w_fit13 || w_imm[0];
      FMT_J:        o_ovf = !w_fit21 || w_imm[0];
      FMT_U:        o_ovf = (w_imm[11:0] != 12'd0);
      default:      o_ovf = 1'b0;
    endcase
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready encoder: decoded RV64I fields in, raw word with
// byte address, illegal and imm_overflow flags out.
// Ports: clk, reset_n, restart, in_valid/in_ready + fields in,
// out_valid/out_ready, instruction, inst_addr, illegal, imm_overflow.
// Optional check: INSTRUCTION_ENCODER_IMM_CHECK_EN.
module instruction_encoder
  import instruction_pkg::*;
#(
  parameter int unsigned          WORDSIZE  = 64,
  parameter int unsigned          SIZE      = 32,
  parameter logic [WORDSIZE-1:0]  BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     op_code,
  input  logic [F3_W-1:0]     funct3,
  input  logic [F7_W-1:0]     funct7,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [REG_W-1:0]    rd,
  input  logic [IMM_W-1:0]    imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     instruction,
  output logic [WORDSIZE-1:0] inst_addr,
  output logic                illegal,
  output logic                imm_overflow
);

  logic w_s2_can_load;
  logic w_in_fire;
  fields_t w_in_f;
  logic [INST_W-1:0] w_word;
  logic w_ovf;

  logic r_s1_valid;
  fields_t r_s1_f;
  fmt_e r_s1_fmt;
  logic [WORDSIZE-1:0] r_s1_addr;
  logic [WORDSIZE-1:0] r_addr;

  logic r_out_valid;
  logic [SIZE-1:0] r_instr;
  logic [WORDSIZE-1:0] r_inst_addr;
  logic r_illegal;
  logic r_ovf;

  assign w_s2_can_load = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_can_load;
  assign w_in_fire = in_valid && in_ready;

  assign w_in_f = '{
    op:  op_code,
    f3:  funct3,
    f7:  funct7,
    rs1: rs1,
    rs2: rs2,
    rd:  rd,
    imm: imm
  };

  // Restart wins over increment; the word accepted this
  // cycle has already latched the old address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= BASE_ADDR;
    end else if (restart) begin
      r_addr <= BASE_ADDR;
    end else if (w_in_fire) begin
      r_addr <= r_addr + WORDSIZE'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_f     <= '0;
      r_s1_fmt   <= FMT_ILL;
      r_s1_addr  <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_f     <= w_in_f;
      r_s1_fmt   <= op_fmt(op_code);
      r_s1_addr  <= r_addr;
    end else if (w_s2_can_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  instruction_imm_packer u_packer (
    .i_fmt  (r_s1_fmt),
    .i_f    (r_s1_f),
    .o_word (w_word),
    .o_ovf  (w_ovf)
  );

  // Payload only moves when stage 2 may load, so it
  // holds steady under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_inst_addr <= '0;
      r_illegal   <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_s2_can_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr     <= w_word;
        r_inst_addr <= r_s1_addr;
        r_illegal   <= (r_s1_fmt == FMT_ILL);
        r_ovf       <= w_ovf;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign instruction  = r_instr;
  assign inst_addr    = r_inst_addr;
  assign illegal      = r_illegal;
  assign imm_overflow = r_ovf;

endmodule
